// File: rtl/ascon_masker_if.sv
// Stream bundle for ascon_masker: unmasked words + randomness in, a shared
// 320-bit state out, plus a debug view of the fill FSM.
interface ascon_masker_if #(
    parameter int D        = 2,
    parameter int RND_BITS = (D - 1) * 64
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. Valid never depends on ready; ready may depend on the partner
    // valid (data and randomness are only ever consumed together).
    logic                flush_i;
    logic [63:0]         data_i;
    logic                data_valid_i;
    logic                data_ready_o;
    logic [RND_BITS-1:0] rnd_i;
    logic                rnd_valid_i;
    logic                rnd_ready_o;
    logic [D*64-1:0]     x0_o;
    logic [D*64-1:0]     x1_o;
    logic [D*64-1:0]     x2_o;
    logic [D*64-1:0]     x3_o;
    logic [D*64-1:0]     x4_o;
    logic                state_valid_o;
    logic                state_ready_i;
    logic                busy_o;
    logic                dbg_full;
    logic [2:0]          dbg_idx;

    modport slave (
        input  flush_i, data_i, data_valid_i, rnd_i, rnd_valid_i, state_ready_i,
        output data_ready_o, rnd_ready_o, x0_o, x1_o, x2_o, x3_o, x4_o,
        output state_valid_o, busy_o, dbg_full, dbg_idx
    );

    modport master (
        output flush_i, data_i, data_valid_i, rnd_i, rnd_valid_i, state_ready_i,
        input  data_ready_o, rnd_ready_o, x0_o, x1_o, x2_o, x3_o, x4_o,
        input  state_valid_o, busy_o, dbg_full, dbg_idx
    );
endinterface

// File: rtl/ascon_masker.sv
// Boolean masking encoder: splits five unmasked 64-bit words into D shares each
// and presents the complete shared Ascon state to the masked permutation.
module ascon_masker #(
    parameter int D        = 2,
    parameter int RND_BITS = (D - 1) * 64
) (
    input  logic           clk,
    input  logic           rst,
    ascon_masker_if.slave  bus
);
    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t          state;
    logic [2:0]      idx;
    logic [D*64-1:0] x_q [5];
    logic [63:0]     rnd_sum;
    logic [D*64-1:0] shares;
    logic            in_fill;
    logic            accept;

    assign in_fill = (state == FILL);

    // flush wins over a coincident word, so nothing is consumed that cycle.
    assign bus.data_ready_o = in_fill & ~bus.flush_i & bus.rnd_valid_i;
    assign bus.rnd_ready_o  = in_fill & ~bus.flush_i & bus.data_valid_i;
    assign accept           = in_fill & ~bus.flush_i & bus.data_valid_i & bus.rnd_valid_i;

    always_comb begin
        rnd_sum = '0;
        for (int k = 0; k < D - 1; k++) begin
            rnd_sum = rnd_sum ^ bus.rnd_i[64*k +: 64];
        end
        shares = {bus.rnd_i[(D-1)*64-1:0], bus.data_i ^ rnd_sum};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            idx   <= 3'd0;
            for (int i = 0; i < 5; i++) x_q[i] <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (bus.flush_i) begin
                        idx <= 3'd0;
                        for (int i = 0; i < 5; i++) x_q[i] <= '0;
                    end else if (accept) begin
                        for (int i = 0; i < 5; i++) begin
                            if (idx == 3'(i)) x_q[i] <= shares;
                        end
                        if (idx == 3'd4) begin
                            idx   <= 3'd0;
                            state <= FULL;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                FULL: begin
                    // Zeroize on hand-off so no share outlives its transfer.
                    if (bus.state_ready_i) begin
                        state <= FILL;
                        for (int i = 0; i < 5; i++) x_q[i] <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.x0_o          = x_q[0];
    assign bus.x1_o          = x_q[1];
    assign bus.x2_o          = x_q[2];
    assign bus.x3_o          = x_q[3];
    assign bus.x4_o          = x_q[4];
    assign bus.state_valid_o = (state == FULL);
    assign bus.busy_o        = (state == FULL) | (idx != 3'd0);
    assign bus.dbg_full      = (state == FULL);
    assign bus.dbg_idx       = idx;
endmodule

// File: tb/tb_ascon_masker.sv
// Bench for ascon_masker: queue-based reference model checked every cycle for
// D=2, hand-computed literals, and a randomized D=3 share-structure check.
module tb_ascon_masker;
  localparam int D   = 2;
  localparam int RB  = 64;
  localparam int W   = D * 64;
  localparam int D3  = 3;
  localparam int RB3 = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ascon_masker_if #(.D(D), .RND_BITS(RB)) bus ();
  ascon_masker_if #(.D(D3), .RND_BITS(RB3)) bus3 ();

  ascon_masker #(.D(D), .RND_BITS(RB)) dut (.clk(clk), .rst(rst), .bus(bus));
  ascon_masker #(.D(D3), .RND_BITS(RB3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model (D=2) ----------------
  logic [63:0]    exp_q[$];
  logic [RB-1:0]  rnd_q[$];
  bit             mdl_full = 1'b0;
  bit             mdl_live = 1'b0;
  logic [W-1:0]   dx [5];

  assign dx[0] = bus.x0_o;
  assign dx[1] = bus.x1_o;
  assign dx[2] = bus.x2_o;
  assign dx[3] = bus.x3_o;
  assign dx[4] = bus.x4_o;

  function automatic logic [W-1:0] share_pack(input logic [63:0] d, input logic [RB-1:0] r);
    logic [W-1:0] p;
    logic [63:0]  s0;
    s0 = d;
    p  = '0;
    for (int k = 1; k < D; k++) begin
      p[64*k +: 64] = r[64*(k-1) +: 64];
      s0 = s0 ^ r[64*(k-1) +: 64];
    end
    p[63:0] = s0;
    return p;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mdl_live = 1'b1;
      exp_q.delete();
      rnd_q.delete();
      mdl_full = 1'b0;
    end else if (mdl_full) begin
      if (bus.state_ready_i) begin
        exp_q.delete();
        rnd_q.delete();
        mdl_full = 1'b0;
      end
    end else if (bus.flush_i) begin
      exp_q.delete();
      rnd_q.delete();
    end else if (bus.data_valid_i && bus.rnd_valid_i) begin
      exp_q.push_back(bus.data_i);
      rnd_q.push_back(bus.rnd_i);
      if (exp_q.size() == 5) mdl_full = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (mdl_live) begin
      for (int k = 0; k < 5; k++) begin
        logic [W-1:0] ex;
        ex = (k < exp_q.size()) ? share_pack(exp_q[k], rnd_q[k]) : '0;
        chk($sformatf("model_x%0d", k), 192'(dx[k]), 192'(ex));
      end
      chk("model_state_valid", 192'(bus.state_valid_o), 192'(mdl_full));
      chk("model_busy", 192'(bus.busy_o), 192'(mdl_full || exp_q.size() > 0));
      chk("model_data_ready", 192'(bus.data_ready_o),
          192'(!mdl_full && !bus.flush_i && bus.rnd_valid_i));
      chk("model_rnd_ready", 192'(bus.rnd_ready_o),
          192'(!mdl_full && !bus.flush_i && bus.data_valid_i));
      chk("model_idx", 192'(bus.dbg_idx), 192'(mdl_full ? 0 : exp_q.size()));
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input bit dv, input bit rv, input bit fl, input bit sr,
                       input logic [63:0] d, input logic [RB-1:0] r);
    bus.data_valid_i  = dv;
    bus.rnd_valid_i   = rv;
    bus.flush_i       = fl;
    bus.state_ready_i = sr;
    bus.data_i        = d;
    bus.rnd_i         = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 64'h0, '0);
  endtask

  task automatic fill5(input logic [63:0] base, input logic [RB-1:0] r);
    for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, base + 64'(i), r);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0]    d3 [5];
    logic [RB3-1:0] r3 [5];
    logic [191:0]   p;

    rst = 1'b1;
    bus.data_valid_i = 0; bus.rnd_valid_i = 0; bus.flush_i = 0;
    bus.state_ready_i = 0; bus.data_i = '0; bus.rnd_i = '0;
    bus3.data_valid_i = 0; bus3.rnd_valid_i = 0; bus3.flush_i = 0;
    bus3.state_ready_i = 0; bus3.data_i = '0; bus3.rnd_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_x0", 192'(bus.x0_o), 192'(0));
    chk("reset_valid", 192'(bus.state_valid_o), 192'(0));
    chk("reset_busy", 192'(bus.busy_o), 192'(0));
    rst = 1'b0;

    // Basic fill
    fill5(64'h1, {64{1'b1}});
    idle(0);
    bus.data_valid_i = 0; bus.rnd_valid_i = 0;
    chk("basic_valid", 192'(bus.state_valid_o), 192'(1));
    chk("basic_x0", 192'(bus.x0_o), 192'(128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFE));
    chk("basic_x4", 192'(bus.x4_o), 192'(128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFA));
    chk("basic_x2_xor", 192'(bus.x2_o[63:0] ^ bus.x2_o[127:64]), 192'(3));

    // Back-pressure with data offered throughout FULL
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 0, 64'hDEAD, 64'hBEEF);
      if (i == 5) chk("bp_data_ready", 192'(bus.data_ready_o), 192'(0));
    end
    chk("bp_x3_stable", 192'(bus.x3_o), 192'(128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFB));
    drive(0, 0, 0, 1, 64'h0, '0);
    chk("bp_after_valid", 192'(bus.state_valid_o), 192'(0));
    chk("bp_after_x0", 192'(bus.x0_o), 192'(0));
    drive(1, 1, 0, 0, 64'h0123456789ABCDEF, 64'h0F0F0F0F0F0F0F0F);
    chk("bp_next_x0", 192'(bus.x0_o), 192'(128'h0F0F0F0F0F0F0F0F_0E2C4A6886A4C2E0));
    chk("bp_next_idx", 192'(bus.dbg_idx), 192'(1));

    // Joint-consumption stall
    for (int i = 0; i < 3; i++) begin
      bus.data_valid_i = 1; bus.rnd_valid_i = 0; bus.data_i = 64'h77;
      #1;
      chk("stall_rnd_ready", 192'(bus.rnd_ready_o), 192'(1));
      chk("stall_data_ready", 192'(bus.data_ready_o), 192'(0));
      drive(1, 0, 0, 0, 64'h77, 64'h55);
    end
    chk("stall_idx", 192'(bus.dbg_idx), 192'(1));
    drive(1, 1, 0, 0, 64'h77, 64'h55);
    chk("stall_x1", 192'(bus.x1_o), 192'(128'h55_0000000000000022));

    // Flush after 3 accepts, with valid data present
    drive(1, 1, 0, 0, 64'h88, 64'h1);
    bus.data_valid_i = 1; bus.rnd_valid_i = 1; bus.flush_i = 1;
    #1;
    chk("flush_data_ready", 192'(bus.data_ready_o), 192'(0));
    chk("flush_rnd_ready", 192'(bus.rnd_ready_o), 192'(0));
    drive(1, 1, 1, 0, 64'h99, 64'h2);
    chk("flush_idx", 192'(bus.dbg_idx), 192'(0));
    chk("flush_x0", 192'(bus.x0_o), 192'(0));
    chk("flush_busy", 192'(bus.busy_o), 192'(0));
    fill5(64'h10, '0);
    chk("flush_refill_x0", 192'(bus.x0_o), 192'(128'h10));
    chk("flush_refill_x2", 192'(bus.x2_o), 192'(128'h12));
    drive(0, 0, 0, 1, 64'h0, '0);

    // Reset mid-fill and in FULL
    drive(1, 1, 0, 0, 64'hA, 64'hB);
    drive(1, 1, 0, 0, 64'hC, 64'hD);
    chk("midfill_idx", 192'(bus.dbg_idx), 192'(2));
    bus.data_valid_i = 1; bus.rnd_valid_i = 1;
    pulse_rst();
    chk("rst_fill_x0", 192'(bus.x0_o), 192'(0));
    chk("rst_fill_idx", 192'(bus.dbg_idx), 192'(0));
    fill5(64'h20, 64'h3);
    pulse_rst();
    chk("rst_full_valid", 192'(bus.state_valid_o), 192'(0));
    chk("rst_full_x4", 192'(bus.x4_o), 192'(0));
    fill5(64'h30, 64'h1);
    chk("post_rst_x0", 192'(bus.x0_o), 192'(128'h1_0000000000000031));
    chk("post_rst_valid", 192'(bus.state_valid_o), 192'(1));
    drive(0, 0, 0, 1, 64'h0, '0);
    idle(1);

    // D=3 randomized
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 5; i++) begin
        d3[i] = {$urandom(), $urandom()};
        r3[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus3.data_i = d3[i]; bus3.rnd_i = r3[i];
        bus3.data_valid_i = 1; bus3.rnd_valid_i = 1;
        @(posedge clk);
        #1;
      end
      bus3.data_valid_i = 0; bus3.rnd_valid_i = 0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      chk("d3_valid", 192'(bus3.state_valid_o), 192'(1));
      for (int k = 0; k < 5; k++) begin
        case (k)
          0: p = bus3.x0_o;
          1: p = bus3.x1_o;
          2: p = bus3.x2_o;
          3: p = bus3.x3_o;
          default: p = bus3.x4_o;
        endcase
        chk($sformatf("d3_s%0d_x%0d_share1", s, k), 192'(p[127:64]), 192'(r3[k][63:0]));
        chk($sformatf("d3_s%0d_x%0d_share2", s, k), 192'(p[191:128]), 192'(r3[k][127:64]));
        chk($sformatf("d3_s%0d_x%0d_xor", s, k), 192'(p[63:0] ^ p[127:64] ^ p[191:128]),
            192'(d3[k]));
      end
      bus3.state_ready_i = 1;
      @(posedge clk);
      #1;
      bus3.state_ready_i = 0;
      chk("d3_after_valid", 192'(bus3.state_valid_o), 192'(0));
    end

    idle(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
